// File: rtl/drum_audio_tap.sv
// drum_audio_tap: captures the tap node's u(n+1) once per time step,
// converts 1.17 to a 16-bit sample and buffers it for the audio master.
// Ports: clk, rst (sync, active-high), enable, node_valid/node_row/node_u
// (update stream in), audio_data/audio_valid/audio_ready (sample out),
// sim_stall (near-full backpressure), overflow (sticky drop flag),
// step_count (accepted sample count).
module drum_audio_tap #(
  parameter logic [5:0] TAP_ROW    = 6'd16,
  parameter int         FIFO_DEPTH = 8,
  parameter int         GAIN_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        node_valid,
  input  logic [5:0]  node_row,
  input  logic [17:0] node_u,
  output logic [15:0] audio_data,
  output logic        audio_valid,
  input  logic        audio_ready,
  output logic        sim_stall,
  output logic        overflow,
  output logic [31:0] step_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = ARM;
      // Wait for row 0 so captures align to whole time steps.
      ARM: if (node_valid && node_row == 6'd0) state_d = RUN;
      RUN: state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  logic capture;
  assign capture = enable && (state_q == RUN) &&
                   node_valid && (node_row == TAP_ROW);

  // Gain then saturate: the shifted value must still fit 1.17.
  logic signed [25:0] s_ext;
  logic signed [25:0] s_sh;
  logic               fits;
  logic [15:0]        sample;

  assign s_ext  = {{8{node_u[17]}}, node_u};
  assign s_sh   = s_ext <<< GAIN_SHIFT;
  assign fits   = (&s_sh[25:17]) || !(|s_sh[25:17]);
  assign sample = fits ? s_sh[17:2] :
                  (s_sh[25] ? 16'h8000 : 16'h7FFF);

  logic        cv_valid;
  logic [15:0] cv_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      cv_valid <= 1'b0;
      cv_data  <= 16'h0000;
    end else begin
      cv_valid <= capture;
      if (capture) cv_data <= sample;
    end
  end

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  // A pop can only happen on a non-empty FIFO, so no bypass exists.
  assign pop     = (count != '0) && audio_ready;
  assign push_ok = cv_valid && (!full || pop);

  always_comb begin
    count_d = count;
    if (push_ok && !pop)      count_d = count + CW'(1);
    else if (!push_ok && pop) count_d = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 16'h0000;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      audio_valid <= 1'b0;
      sim_stall   <= 1'b0;
      overflow    <= 1'b0;
      step_count  <= 32'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= cv_data;
        wr_ptr      <= wr_ptr + AW'(1);
        step_count  <= step_count + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (cv_valid && full && !pop) overflow <= 1'b1;
      count       <= count_d;
      audio_valid <= (count_d != '0);
      sim_stall   <= (count_d >= CW'(FIFO_DEPTH - 1));
    end
  end

  assign audio_data = mem[rd_ptr];

endmodule

// File: tb/tb_drum_audio_tap.sv
// tb_drum_audio_tap: random and directed stimulus for drum_audio_tap
// (gain 0 and gain 2) checked against a queue-based sample model.
module tb_drum_audio_tap;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        node_valid;
  logic [5:0]  node_row;
  logic [17:0] node_u;
  logic        audio_ready;

  logic [15:0] a0_data,  a2_data;
  logic        a0_valid, a2_valid;
  logic        a0_stall, a2_stall;
  logic        a0_ovf,   a2_ovf;
  logic [31:0] a0_steps, a2_steps;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  drum_audio_tap #(.TAP_ROW(6'd16), .FIFO_DEPTH(8), .GAIN_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable),
    .node_valid(node_valid), .node_row(node_row), .node_u(node_u),
    .audio_data(a0_data), .audio_valid(a0_valid),
    .audio_ready(audio_ready), .sim_stall(a0_stall),
    .overflow(a0_ovf), .step_count(a0_steps)
  );

  drum_audio_tap #(.TAP_ROW(6'd16), .FIFO_DEPTH(8), .GAIN_SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable),
    .node_valid(node_valid), .node_row(node_row), .node_u(node_u),
    .audio_data(a2_data), .audio_valid(a2_valid),
    .audio_ready(audio_ready), .sim_stall(a2_stall),
    .overflow(a2_ovf), .step_count(a2_steps)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Real value u*2^sh clipped to the 1.17 range, then truncated to 1.15.
  function automatic logic [15:0] conv(logic [17:0] u, int sh);
    longint v;
    v = longint'($signed(u)) * (longint'(1) << sh);
    if (v > 131071)  return 16'h7FFF;
    if (v < -131072) return 16'h8000;
    v = v >>> 2;
    return v[15:0];
  endfunction

  // Model: raw samples queued; both instances share timing.
  int           mst;
  bit           pv;
  logic [17:0]  pu;
  logic [17:0]  q[$];
  bit           movf;
  int unsigned  msteps;
  bit           mpop;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mst = 0; pv = 1'b0; q.delete(); movf = 1'b0; msteps = 0;
    end else begin
      mpop = (q.size() != 0) && audio_ready;
      if (mpop) void'(q.pop_front());
      if (pv) begin
        if (q.size() < 8) begin
          q.push_back(pu);
          msteps++;
        end else begin
          movf = 1'b1;
        end
      end
      pv = enable && (mst == 2) && node_valid && (node_row == 6'd16);
      pu = node_u;
      if (!enable) mst = 0;
      else if (mst == 0) mst = 1;
      else if (mst == 1 && node_valid && node_row == 6'd0) mst = 2;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid0", 32'(a0_valid), 32'(q.size() != 0));
      check("valid2", 32'(a2_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("data0", 32'(a0_data), 32'(conv(q[0], 0)));
        check("data2", 32'(a2_data), 32'(conv(q[0], 2)));
      end
      check("stall0", 32'(a0_stall), 32'(q.size() >= 7));
      check("stall2", 32'(a2_stall), 32'(q.size() >= 7));
      check("ovf0", 32'(a0_ovf), 32'(movf));
      check("ovf2", 32'(a2_ovf), 32'(movf));
      check("steps0", a0_steps, msteps);
      check("steps2", a2_steps, msteps);
    end
  end

  task automatic cyc(bit nv, logic [5:0] row, logic [17:0] u);
    node_valid = nv;
    node_row   = row;
    node_u     = u;
    @(negedge clk);
  endtask

  task automatic step(logic [17:0] u);
    cyc(1'b1, 6'd0, 18'($urandom));
    cyc(1'b1, 6'd16, u);
    cyc(1'b0, 6'd0, 18'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 6'd0, 18'd0);
    cyc(1'b0, 6'd0, 18'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; audio_ready = 1'b0;
    node_valid = 1'b0; node_row = 6'd0; node_u = 18'd0;
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    check("rst_data", 32'(a0_data), 32'h0);
    check("rst_steps", a0_steps, 32'd0);

    // Tap strobe before any row 0 is ignored while armed.
    enable = 1'b1;
    cyc(1'b0, 6'd0, 18'd0);
    cyc(1'b1, 6'd16, 18'h08000);
    cyc(1'b0, 6'd0, 18'd0);
    cyc(1'b0, 6'd0, 18'd0);
    check("arm_none", 32'(a0_valid), 32'd0);

    // First capture: two cycles after the strobe.
    audio_ready = 1'b1;
    step(18'h08000);
    check("t1_data", 32'(a0_data), 32'h2000);
    check("t1_steps", a0_steps, 32'd1);
    step(18'h10000);
    check("sat_pos", 32'(a2_data), 32'h7FFF);
    step(18'h30000);
    check("sat_neg", 32'(a2_data), 32'h8000);
    cyc(1'b0, 6'd0, 18'd0);

    // Fill to full, then a push coinciding with a pop.
    do_reset();
    audio_ready = 1'b0;
    cyc(1'b0, 6'd0, 18'd0);
    for (int i = 0; i < 8; i++) step(18'($urandom));
    check("full_stall", 32'(a0_stall), 32'd1);
    cyc(1'b1, 6'd16, 18'h1F000);
    audio_ready = 1'b1;
    cyc(1'b0, 6'd0, 18'd0);
    audio_ready = 1'b0;
    cyc(1'b0, 6'd0, 18'd0);
    check("swap_ovf", 32'(a0_ovf), 32'd0);
    check("swap_steps", a0_steps, 32'd9);

    // Overflow: nine captures with no consumer, then drain in order.
    do_reset();
    cyc(1'b0, 6'd0, 18'd0);
    for (int i = 0; i < 9; i++) step(18'($urandom));
    check("ovf_set", 32'(a0_ovf), 32'd1);
    check("ovf_steps", a0_steps, 32'd8);
    audio_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b0, 6'd0, 18'd0);

    // Enable drop with three buffered: drains, no new captures.
    audio_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(18'($urandom));
    enable = 1'b0;
    cyc(1'b0, 6'd0, 18'd0);
    for (int i = 0; i < 3; i++) step(18'($urandom));
    audio_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 6'd0, 18'd0);
    check("idle_steps", a0_steps, 32'd11);

    // Reset mid-transfer.
    enable = 1'b1;
    audio_ready = 1'b0;
    cyc(1'b0, 6'd0, 18'd0);
    step(18'h00400);
    step(18'h3FC00);
    rst = 1'b1;
    cyc(1'b0, 6'd0, 18'd0);
    rst = 1'b0;
    check("rst_mid", 32'(a0_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [5:0]  r;
      logic [17:0] u;
      int          sel;
      sel = int'($urandom_range(0, 9));
      r = (sel < 3) ? 6'd0 : (sel < 7) ? 6'd16 : 6'($urandom);
      sel = int'($urandom_range(0, 3));
      u = (sel == 0) ? 18'h1FFFF : (sel == 1) ? 18'h20000 : 18'($urandom);
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      if ($urandom_range(0, 999) < 2) rst = 1'b1;
      else rst = 1'b0;
      audio_ready = ($urandom_range(0, 99) < 35);
      cyc(($urandom_range(0, 99) < 60), r, u);
    end
    rst = 1'b0;
    cyc(1'b0, 6'd0, 18'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
